// File: rtl/seg_scan_display_if.sv
// Bus for the multiplexed 7-segment scanner: digit/attribute inputs with an
// update strobe, plus the registered segment/enable drive and the frame strobe.
interface seg_scan_display_if #(
  parameter int unsigned NUM_DIG = 8
) ();
  logic                   upd;
  logic [4*NUM_DIG-1:0]   digits;
  logic [NUM_DIG-1:0]     dp;
  logic [NUM_DIG-1:0]     blank;
  logic [NUM_DIG-1:0]     blink;
  logic [7:0]             seg_out;
  logic [7:0]             seg_en;
  logic                   frame_tick;

  modport master (
    output upd, digits, dp, blank, blink,
    input  seg_out, seg_en, frame_tick
  );

  modport slave (
    input  upd, digits, dp, blank, blink,
    output seg_out, seg_en, frame_tick
  );
endinterface

// File: rtl/seg_scan_display.sv
// Time-multiplexed hex display scanner with double-buffered digit attributes,
// per-slot dead time, blanking and frame-synchronous blinking.
module seg_scan_display #(
  parameter int unsigned NUM_DIG    = 8,
  parameter int unsigned SCAN_DIV   = 100000,
  parameter int unsigned BLANK_CYC  = 16,
  parameter int unsigned BLINK_DIV  = 250,
  parameter bit          ACTIVE_LOW = 1'b1
) (
  input logic                clk,
  input logic                rst,
  seg_scan_display_if.slave  bus
);

  localparam int unsigned CntW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned IdxW = (NUM_DIG > 1) ? $clog2(NUM_DIG) : 1;
  localparam int unsigned BlkW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [7:0]  SegOff = {8{ACTIVE_LOW}};

  logic [CntW-1:0]        div_cnt_q, div_cnt_d;
  logic [IdxW-1:0]        idx_q, idx_d;
  logic [BlkW-1:0]        blink_cnt_q, blink_cnt_d;
  logic                   blink_phase_q, blink_phase_d;
  logic                   div_last, idx_last, frame_tick;

  logic [4*NUM_DIG-1:0]   dig_p_q, dig_p_d, dig_a_q, dig_a_d;
  logic [NUM_DIG-1:0]     dp_p_q, dp_p_d, dp_a_q, dp_a_d;
  logic [NUM_DIG-1:0]     blank_p_q, blank_p_d, blank_a_q, blank_a_d;
  logic [NUM_DIG-1:0]     blink_p_q, blink_p_d, blink_a_q, blink_a_d;

  logic [7:0]             seg_out_q, seg_out_d, seg_en_q, seg_en_d;
  logic [3:0]             nib;
  logic                   cur_dp, cur_blank, cur_blink, lit;
  logic [7:0]             seg_hi, en_hi;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

  // Scan timing and blink phase.
  always_comb begin
    div_last   = (div_cnt_q == CntW'(SCAN_DIV - 1));
    idx_last   = (idx_q == IdxW'(NUM_DIG - 1));
    frame_tick = div_last && idx_last && !rst;

    div_cnt_d = div_last ? '0 : div_cnt_q + CntW'(1);
    idx_d     = idx_q;
    if (div_last) begin
      idx_d = idx_last ? '0 : idx_q + IdxW'(1);
    end

    blink_cnt_d   = blink_cnt_q;
    blink_phase_d = blink_phase_q;
    if (frame_tick) begin
      if (blink_cnt_q == BlkW'(BLINK_DIV - 1)) begin
        blink_cnt_d   = '0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + BlkW'(1);
      end
    end
  end

  // Active set loads from the post-update pending set, so an upd coinciding
  // with frame_tick lands in both at once.
  always_comb begin
    dig_p_d   = bus.upd ? bus.digits : dig_p_q;
    dp_p_d    = bus.upd ? bus.dp     : dp_p_q;
    blank_p_d = bus.upd ? bus.blank  : blank_p_q;
    blink_p_d = bus.upd ? bus.blink  : blink_p_q;

    dig_a_d   = frame_tick ? dig_p_d   : dig_a_q;
    dp_a_d    = frame_tick ? dp_p_d    : dp_a_q;
    blank_a_d = frame_tick ? blank_p_d : blank_a_q;
    blink_a_d = frame_tick ? blink_p_d : blink_a_q;
  end

  always_comb begin
    nib       = '0;
    cur_dp    = 1'b0;
    cur_blank = 1'b1;
    cur_blink = 1'b0;
    for (int i = 0; i < NUM_DIG; i++) begin
      if (idx_q == IdxW'(i)) begin
        nib       = dig_a_q[4*i +: 4];
        cur_dp    = dp_a_q[i];
        cur_blank = blank_a_q[i];
        cur_blink = blink_a_q[i];
      end
    end

    lit = (32'(div_cnt_q) >= BLANK_CYC) && !cur_blank && !(cur_blink && blink_phase_q);

    en_hi = '0;
    for (int i = 0; i < NUM_DIG; i++) begin
      en_hi[i] = lit && (idx_q == IdxW'(i));
    end
    seg_hi = lit ? {cur_dp, hex7(nib)} : 8'h00;

    seg_out_d = ACTIVE_LOW ? ~seg_hi : seg_hi;
    seg_en_d  = ACTIVE_LOW ? ~en_hi  : en_hi;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt_q     <= '0;
      idx_q         <= '0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
      dig_p_q       <= '0;
      dp_p_q        <= '0;
      blank_p_q     <= '1;
      blink_p_q     <= '0;
      dig_a_q       <= '0;
      dp_a_q        <= '0;
      blank_a_q     <= '1;
      blink_a_q     <= '0;
      seg_out_q     <= SegOff;
      seg_en_q      <= SegOff;
    end else begin
      div_cnt_q     <= div_cnt_d;
      idx_q         <= idx_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
      dig_p_q       <= dig_p_d;
      dp_p_q        <= dp_p_d;
      blank_p_q     <= blank_p_d;
      blink_p_q     <= blink_p_d;
      dig_a_q       <= dig_a_d;
      dp_a_q        <= dp_a_d;
      blank_a_q     <= blank_a_d;
      blink_a_q     <= blink_a_d;
      seg_out_q     <= seg_out_d;
      seg_en_q      <= seg_en_d;
    end
  end

  assign bus.seg_out    = seg_out_q;
  assign bus.seg_en     = seg_en_q;
  assign bus.frame_tick = frame_tick;

endmodule
